uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer and issue controller that sits directly upstream of the UART transmitter. It accepts payload words from system logic through a ready/valid write port and stores them in a DEPTH-entry circular FIFO. It presents them one at a time to the transmitter's `uart_tx_en`/`uart_tx_data` inputs, pacing issue on the transmitter's `uart_tx_busy` output. Its purpose is to let software or upstream logic burst several bytes without tracking per-byte UART completion.

## Interface
- `PAYLOAD_BITS`, 8, width of each stored word; must match the transmitter's `PAYLOAD_BITS`.
- `DEPTH`, 16, number of FIFO entries; power of two, minimum 2.
- `clk` input 1: system clock.
- `resetn` input 1: reset, asynchronous and active-low. All state clears immediately on assertion.
- `wr_data` input PAYLOAD_BITS: word to enqueue.
- `wr_en` input 1: enqueue request. Accepted only when `wr_ready`=1.
- `wr_ready` output 1: FIFO not full.
- `flush` input 1: synchronous clear of FIFO contents and the overflow flag.
- `fifo_count` output $clog2(DEPTH)+1: number of stored words, 0..DEPTH.
- `overflow` output 1: sticky; set when `wr_en`=1 while `wr_ready`=0.
- `tx_data` output PAYLOAD_BITS: drives the transmitter's `uart_tx_data`.
- `tx_en` output 1: drives the transmitter's `uart_tx_en`. Single-cycle pulse.
- `tx_busy` input 1: connected from the transmitter's `uart_tx_busy`.

## Operation
- Storage: `mem[DEPTH]`, `wr_ptr` and `rd_ptr` of width $clog2(DEPTH), and a registered `fifo_count`.
  - Pointers wrap modulo DEPTH.
  - `wr_ready` = (`fifo_count` != DEPTH).
- Write: on a clock edge with `wr_en`=1 and `wr_ready`=1:
  - `mem[wr_ptr]` <= `wr_data`; `wr_ptr` increments.
- Rejected write: `wr_en`=1 while full.
  - The write is dropped.
  - `overflow` <= 1 and stays set until `flush` or reset.
  - A pop in the same cycle does not make room for that write, because `wr_ready` is based on the registered count.
- Count update: +1 on write only, −1 on pop only, unchanged when both occur in the same cycle.
- Issue FSM:
  - IDLE: if `fifo_count` != 0 and `tx_busy`=0, then pop. The pop sets `tx_data` <= `mem[rd_ptr]`, `rd_ptr`++, `tx_en` <= 1, and the FSM moves to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `tx_en` <= 0 and go to WAIT unconditionally. This covers the one cycle before the transmitter raises busy.
  - WAIT: if `tx_busy`=0, go to IDLE; otherwise stay in WAIT.
  - Undefined encodings go to IDLE.
- `tx_data` holds its value until the next pop. It is not cleared when the FSM returns to IDLE.
- `flush` (highest priority after reset):
  - Pointers, count and `overflow` clear to 0.
  - Any `wr_en` in the same cycle is ignored.
  - The FSM and `tx_en` are not affected. A byte already issued completes normally.
  - If the FSM is in IDLE, no new pop occurs in that cycle.

## Timing
- Reset values:
  - `tx_en`=0, `tx_data`=0.
  - `wr_ready`=1, `fifo_count`=0, `overflow`=0.
  - FSM in IDLE, pointers at 0.
  - If reset asserts mid-transfer, a pending `tx_en` pulse drops immediately.
- All outputs are registered, except `wr_ready`, which decodes the registered count.
- First-byte latency: if `wr_en` is sampled at edge k into an empty FIFO while the transmitter is idle, `tx_en` is high for exactly the cycle between edges k+1 and k+2.
- Back-to-back spacing: the next `tx_en` occurs no earlier than 2 cycles after `tx_busy` falls. This is one cycle in WAIT→IDLE, then the issue edge.
- `tx_en` is never high on two consecutive cycles.
- `tx_en` is never asserted while `tx_busy`=1.
- Full boundary: after DEPTH writes with no pops, `wr_ready`=0 and `fifo_count`=DEPTH.
- Empty boundary: IDLE never pops when `fifo_count`=0.

## Test plan
- Reset then single write 0xA5 at edge k:
  - `tx_en` pulses for one cycle after edge k+1 with `tx_data`=0xA5.
  - `fifo_count` goes 0→1→0.
- Write 0x01,0x02,0x03 back-to-back, with the real transmitter and CYCLES_PER_BIT reduced to 4:
  - The line shows three frames in order.
  - Each `tx_en` comes only after `tx_busy` has fallen.
  - There is no overlap between frames.
- Write DEPTH+2 words with `tx_busy` forced to 1:
  - `wr_ready` falls after word 16.
  - Words 17 and 18 are dropped and `overflow`=1.
  - Release busy: exactly 16 words are issued, in order, including across pointer wrap.
- Simultaneous write and pop at `fifo_count`=5: `fifo_count` stays 5 and the data order is preserved.
- `flush` while in WAIT with 4 words queued:
  - `fifo_count`=0 and `overflow`=0.
  - The in-flight byte completes.
  - No further `tx_en` is asserted.
- Assert `resetn`=0 asynchronously, mid-cycle, during ISSUE:
  - `tx_en` goes to 0 immediately.
  - `fifo_count`=0 and `wr_ready`=1.
  - After release, the FSM stays in IDLE.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter.
// Issues one word at a time, paced on the transmitter's busy flag.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    wr_en,
  output logic                    wr_ready,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    tx_en_q, tx_en_d;
  logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic                    do_wr, do_pop;

  assign wr_ready   = (count_q != CW'(DEPTH));
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;

  always_comb begin
    do_wr     = wr_en & wr_ready & ~flush;
    do_pop    = (state_q == S_IDLE) & (count_q != '0)
              & ~tx_busy & ~flush;
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (do_pop) begin
          tx_en_d   = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + AW'(1);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (!tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (wr_en && !wr_ready) ovf_d = 1'b1;
    count_d = count_q + CW'(do_wr) - CW'(do_pop);

    // Flush clears storage state only; an issued byte runs to completion.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model
// plus a simple behavioural transmitter driving tx_busy.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       resetn;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       wr_ready;
  logic       flush;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;

  uart_tx_fifo #(.PAYLOAD_BITS(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         iss_cyc[$];
  int         m_cnt = 0;
  bit         m_ovf = 0;
  int         cyc = 0;
  int         fall_cyc = -100;
  int         frame_len = 5;
  int         rem = 0;
  bit         pend = 0;
  bit         xbusy = 0;
  bit         force_busy = 0;
  bit         prev_tx_en = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int         pre_cnt;
    bit         w, f, acc;
    logic [7:0] d, e;
    pre_cnt = m_cnt;
    w = wr_en;
    f = flush;
    d = wr_data;
    @(posedge clk);
    #1;
    cyc++;
    acc = w && !f && (pre_cnt != DEPTH);
    if (f) m_ovf = 0;
    else if (w && pre_cnt == DEPTH) m_ovf = 1;
    if (tx_en) begin
      iss_cyc.push_back(cyc);
      check("pop_nonempty", (pre_cnt != 0), 1);
      check("pop_no_flush", f, 0);
      check("tx_en_busy", tx_busy, 0);
      check("tx_en_consec", prev_tx_en, 0);
      check("issue_gap", (cyc - fall_cyc >= 2), 1);
      e = 8'h00;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("tx_data_order", tx_data, e);
      m_cnt--;
    end
    if (f) begin
      exp_q.delete();
      m_cnt = 0;
    end
    if (acc) begin
      exp_q.push_back(d);
      m_cnt++;
    end
    check("count", fifo_count, m_cnt);
    check("overflow", overflow, m_ovf);
    check("wr_ready", wr_ready, (m_cnt != DEPTH));
    if (pend) begin
      xbusy = 1;
      rem = frame_len;
      pend = 0;
    end else if (xbusy) begin
      rem--;
      if (rem == 0) begin
        xbusy = 0;
        fall_cyc = cyc;
      end
    end
    if (tx_en) pend = 1;
    tx_busy = force_busy | xbusy;
    prev_tx_en = tx_en;
  endtask

  task automatic drain();
    int b = 0;
    while (!(m_cnt == 0 && !xbusy && !pend) && b < 3000) begin
      tick();
      b++;
    end
    check("drain_done", (m_cnt == 0 && !xbusy && !pend), 1);
    repeat (2) tick();
  endtask

  initial begin
    resetn  = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    tx_busy = 1'b0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    resetn = 1'b1;

    // single write: tx_en high between edges k+1 and k+2
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    check("lat_k_tx_en", tx_en, 0);
    check("lat_k_count", fifo_count, 1);
    wr_en = 1'b0;
    tick();
    check("lat_k1_tx_en", tx_en, 1);
    check("lat_k1_data", tx_data, 8'hA5);
    check("lat_k1_count", fifo_count, 0);
    tick();
    check("lat_k2_tx_en", tx_en, 0);
    drain();

    // three back-to-back bytes, 40-cycle frames
    frame_len = 40;
    iss_cyc.delete();
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    drain();
    check("b2b_issued", iss_cyc.size(), 3);
    for (int i = 0; i + 1 < iss_cyc.size(); i++)
      check("b2b_gap", iss_cyc[i+1] - iss_cyc[i], frame_len + 3);

    // fill past full with busy held high
    frame_len = 5;
    force_busy = 1;
    tx_busy = 1'b1;
    tick();
    iss_cyc.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
      if (i == DEPTH - 2) check("almost_full_ready", wr_ready, 1);
      if (i == DEPTH - 1) begin
        check("full_ready", wr_ready, 0);
        check("full_count", fifo_count, DEPTH);
        check("full_no_ovf", overflow, 0);
      end
    end
    wr_en = 1'b0;
    check("ovf_set", overflow, 1);
    force_busy = 0;
    tx_busy = xbusy;
    drain();
    check("wrap_issued", iss_cyc.size(), DEPTH);
    check("ovf_sticky", overflow, 1);

    // simultaneous write and pop at count 5
    force_busy = 1;
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    check("simul_pre_count", fifo_count, 5);
    force_busy = 0;
    tx_busy = 1'b0;
    wr_data = 8'($urandom);
    tick();
    wr_en = 1'b0;
    check("simul_count", fifo_count, 5);
    check("simul_tx_en", tx_en, 1);
    drain();

    // flush while waiting on an in-flight byte
    force_busy = 1;
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    force_busy = 0;
    tx_busy = 1'b0;
    iss_cyc.delete();
    repeat (3) tick();
    check("pre_flush_count", fifo_count, 4);
    check("pre_flush_ovf", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", fifo_count, 0);
    check("flush_ovf", overflow, 0);
    repeat (60) tick();
    check("flush_issued", iss_cyc.size(), 1);
    check("flush_busy_done", tx_busy, 0);

    // asynchronous reset during ISSUE
    wr_en = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    check("pre_rst_tx_en", tx_en, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_tx_en", tx_en, 0);
    check("arst_count", fifo_count, 0);
    check("arst_wr_ready", wr_ready, 1);
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 0;
    pend = 0;
    xbusy = 0;
    rem = 0;
    prev_tx_en = 0;
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    iss_cyc.delete();
    repeat (10) tick();
    check("arst_idle", iss_cyc.size(), 0);

    // randomized traffic: heavy then light load
    frame_len = 3;
    for (int i = 0; i < 800; i++) begin
      wr_en = (($urandom % 3) != 0);
      wr_data = 8'($urandom);
      flush = (($urandom % 60) == 0);
      tick();
    end
    for (int i = 0; i < 800; i++) begin
      wr_en = (($urandom % 8) == 0);
      wr_data = 8'($urandom);
      flush = (($urandom % 200) == 0);
      tick();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
